multicycle_ctrl: RTL

Multi-cycle sequencer for the 2-bit-opcode microprocessor: steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It drives the per-cycle datapath enables (PC, IR, register file, ALU mux, memory) that the single-cycle decoder produces statically. It handles the memory ready handshake and the branch decision, and sits between the instruction register/ALU flags and the shared instruction/data memory port.

---
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the 2-bit-opcode processor. Each instruction
//   walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The datapath enables are
//   decoded combinationally from the state, op, zero and mem_ready inputs.
//   No output register is used.
//
// Optional feature macro: CTRL_PERF_CNT_EN
//   When defined, this adds parameter CNT_W (default 16) and output
//   retired_count. retired_count is a saturating count of retired
//   instructions.
//
// Ports
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   run                 keep executing; low parks in IDLE after the current retire
//   op                  IR opcode: 00 R-type, 01 load, 10 store, 11 branch-if-zero
//   zero                ALU zero flag (used by branch in EXEC)
//   mem_ready           memory completes the current request this cycle
//   mem_req/mem_we      memory request / write strobe
//   mem_addr_sel        0 = PC, 1 = ALU result
//   ir_write            load IR from memory read data
//   pc_write/pc_src     PC update, 0 = PC+1, 1 = branch target
//   reg_write/reg_dst   RF write enable, 1 = rd, 0 = rt
//   mem_to_reg          write-back from memory data
//   alu_src/alu_op      immediate operand / R-type function
//   busy                not IDLE
//   retire              pulse in the final cycle of each instruction
//   retired_count       retired-instruction counter (CTRL_PERF_CNT_EN only)
module multicycle_ctrl
`ifdef CTRL_PERF_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       alu_op,
    output logic       busy,
    output logic       retire
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [1:0] OP_R   = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 1'b0;
        busy         = 1'b1;
        retire       = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_R: begin
                        alu_op    = 1'b1;
                        state_nxt = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src   = 1'b1;
                        state_nxt = S_MEM;
                    end
                    default: begin
                        // Branch resolves here; no MEM/WB stage.
                        pc_write = zero;
                        pc_src   = zero;
                        retire   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // alu_src stays high so the ALU address is stable for the whole handshake.
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op == OP_ST);
                alu_src      = 1'b1;
                if (mem_ready) begin
                    if (op == OP_LD) state_nxt = S_WB;
                    else             retire    = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op == OP_R);
                mem_to_reg = (op == OP_LD);
                retire     = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        // run is only consulted on the retire cycle, so a drop mid-instruction never aborts it.
        if (retire) state_nxt = run ? S_FETCH : S_IDLE;
    end

`ifdef CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    always_ff @(posedge clk) begin
        if (!reset_n)
            retired_count <= '0;
        else if (retire && (retired_count != '1))
            retired_count <= retired_count + CNT_ONE;
    end
`endif

endmodule
